dpram_bank_controller: RTL
==========================

Name: dpram_bank_controller

Overview:
- Front-end controller that sits directly upstream of an array of NUM_BANKS dual_port_memory banks.
- Accepts independent valid/ready write and read requests on a flat address space.
- Decodes the bank select and drives each bank's mem_wr_en/mem_rd_en, write/read, addresses and data_in.
- Collects bank read data, qualified by data_valid, into a credit-controlled response FIFO with a valid/ready output.

Parameters:
- RAM_WIDTH, 64, data width of each bank.
- ADDR_SIZE, 10, per-bank row address width.
- BANK_SEL_BITS, 2, bank-select width; NUM_BANKS = 2**BANK_SEL_BITS.
- RSP_DEPTH, 4, response FIFO depth and maximum outstanding reads (power of two, >= 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_req_valid  in  1  write request valid
- wr_req_ready  out  1  write request ready
- wr_req_addr  in  BANK_SEL_BITS+ADDR_SIZE  write address; bank = MSBs
- wr_req_data  in  RAM_WIDTH  write data
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request ready
- rd_req_addr  in  BANK_SEL_BITS+ADDR_SIZE  read address; bank = MSBs
- rd_rsp_valid  out  1  read response valid
- rd_rsp_ready  in  1  read response ready
- rd_rsp_data  out  RAM_WIDTH  read response data
- mem_wr_en  out  NUM_BANKS  one-hot per-bank write chip enable
- mem_rd_en  out  NUM_BANKS  one-hot per-bank read chip enable
- write  out  1  write control, shared by all banks
- read  out  1  read control, shared by all banks
- wr_address  out  ADDR_SIZE  shared bank write address
- rd_address  out  ADDR_SIZE  shared bank read address
- data_in  out  RAM_WIDTH  shared bank write data
- bank_data_out  in  NUM_BANKS*RAM_WIDTH  concatenated bank data_out; bank k at [k*RAM_WIDTH +: RAM_WIDTH]
- bank_data_valid  in  NUM_BANKS  per-bank data_valid

Behaviour:
- Reset values:
  - All bank-side outputs are 0.
  - rd_rsp_valid = 0 and rd_rsp_data = 0.
  - FIFO is empty, credit counter is 0, read pipeline valids are 0.
  - wr_req_ready = 1.
- Write path:
  - wr_req_ready is constantly 1 out of reset.
  - Accept in cycle N registers the bank signals, which are active for cycle N+1 only:
    - mem_wr_en = one-hot(bank)
    - write = 1
    - wr_address = row
    - data_in = wr_req_data
  - Back-to-back writes are issued every cycle.
- Read path:
  - rd_req_ready = (credits < RSP_DEPTH).
  - Accept in cycle N: credits +1. In cycle N+1 the controller drives mem_rd_en = one-hot(bank), read = 1, rd_address = row. The bank is also recorded in a pipeline register.
  - In cycle N+2 the bank returns data; the controller selects bank_data_out of the recorded bank and pushes it into the FIFO when that bank's bank_data_valid is 1.
  - rd_rsp_valid is asserted from cycle N+3, driven by FIFO not empty. The minimum accept-to-response latency is 3 cycles.
- Response ordering and credits:
  - Responses are returned strictly in request order.
  - A response handshake (rd_rsp_valid & rd_rsp_ready) pops the FIFO and decrements credits by 1.
  - Accept and pop in the same cycle leave credits unchanged.
  - Credits count in-flight plus buffered reads, so the FIFO can never overflow. A push while full cannot occur; the bench asserts this.
- Spurious and missing data_valid:
  - bank_data_valid is ignored unless a tracked read is in its N+2 stage.
  - If the tracked bank's data_valid is low in that stage, this is a protocol error: data is not pushed and a sticky internal error bit is set for assertion checking.
- Same-cycle write and read:
  - A write and a read are issued together in the same cycle, even to the same bank and row.
  - The read returns the pre-write data.
  - The controller does no forwarding.
- Full boundary: with RSP_DEPTH outstanding and rd_rsp_ready = 0, rd_req_ready = 0. It returns to 1 in the cycle after the first pop.
- Reset mid-operation:
  - All in-flight reads and buffered responses are discarded.
  - Credits are cleared.
  - Enables drop to 0 immediately, since the reset is asynchronous.
- Arithmetic: the credit counter is $clog2(RSP_DEPTH)+1 bits wide; FIFO pointers wrap modulo RSP_DEPTH.

Decomposition:
- Shared package dpram_pkg holds:
  - RAM_WIDTH, ADDR_SIZE, BANK_SEL_BITS and NUM_BANKS constants.
  - The bank-select extraction function.
  - The one-hot decode function.
- One sub-module, dpram_rsp_fifo:
  - Synchronous FIFO, RSP_DEPTH x RAM_WIDTH, rst_n asynchronous.
  - Ports push, pop, full, empty.
- The controller holds the request registers, read pipeline, credits and error bit.

Test Plan:
- Write 0xDEADBEEF_00000001 to address 0x405 (bank 1, row 5), then read 0x405 with rd_rsp_ready = 1. Expect mem_wr_en = 4'b0010 for one cycle, then rd_rsp_valid 3 cycles after the read accept with data 0xDEADBEEF_00000001.
- Issue 4 reads to banks 0..3 back-to-back with rd_rsp_ready = 0. Expect rd_req_ready = 0 after the 4th accept. Raising rd_rsp_ready returns 4 responses in request order, and rd_req_ready returns to 1 one cycle after the first pop.
- In the same cycle, write 0xAA to 0x010 (holding 0x55) and read 0x010. Expect the response to be 0x55; a subsequent read returns 0xAA.
- Assert rst_n low with 2 reads in flight and 1 buffered. Expect rd_rsp_valid = 0, rd_req_ready = 1 and all enables 0 immediately. No stale response appears after reset release.
- Inject bank_data_valid[2] = 1 with no read outstanding. Expect no FIFO push and rd_rsp_valid to stay 0.
- Run 1000 cycles of random concurrent reads and writes with random rd_rsp_ready against a scoreboard model. Expect all data to match, with ordering preserved and no overflow assertion firing.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants, types and decode helpers for the dual-port memory bank controller.
// Pure declarations: no latency, no flow control.
// Consumers: dpram_bank_controller (the response FIFO is generic and does not import it).
package dpram_pkg;

    localparam int RAM_WIDTH     = 64;
    localparam int ADDR_SIZE     = 10;
    localparam int BANK_SEL_BITS = 2;
    localparam int NUM_BANKS     = 1 << BANK_SEL_BITS;
    localparam int REQ_ADDR_W    = BANK_SEL_BITS + ADDR_SIZE;

    // One read-pipeline stage: a tracked read and the bank it targets.
    typedef struct packed {
        logic                     vld;
        logic [BANK_SEL_BITS-1:0] bank;
    } rd_stage_t;

    // Bank select is the MSB field of the flat request address.
    function automatic logic [BANK_SEL_BITS-1:0] bank_sel(input logic [REQ_ADDR_W-1:0] addr);
        return addr[REQ_ADDR_W-1 -: BANK_SEL_BITS];
    endfunction

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [BANK_SEL_BITS-1:0] bank);
        return NUM_BANKS'(1) << bank;
    endfunction

endpackage

// File: rtl/dpram_rsp_fifo.sv
// Synchronous DEPTH x WIDTH FIFO holding bank read responses until the consumer takes them.
// Latency: a push is visible at the head (empty deasserts) the cycle after it is written.
// Backpressure: push while full and pop while empty are ignored; upstream credits prevent both.
//
// Ports: clk, rst_n (async active-low); push/push_dat write side; pop/pop_dat read side
// (pop_dat is the current head, forced to 0 when empty); full, empty status.
module dpram_rsp_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/dpram_bank_controller.sv
// Front-end controller for NUM_BANKS dual-port memory banks: decodes bank, drives enables, buffers reads.
// Latency: write reaches the bank 1 cycle after accept; read response is valid 3 cycles after accept.
// Backpressure: writes always accepted; reads accepted only while credits (in-flight + buffered) < RSP_DEPTH.
//
// Ports: wr_req_* / rd_req_* request handshakes on a flat {bank,row} address; rd_rsp_* response handshake;
// mem_wr_en/mem_rd_en one-hot bank enables with shared write/read/wr_address/rd_address/data_in;
// bank_data_out (bank k at [k*RAM_WIDTH +: RAM_WIDTH]) and bank_data_valid returned by the banks.
// Width parameters must match the dpram_pkg constants used by the decode helpers.
module dpram_bank_controller #(
    parameter int RAM_WIDTH     = dpram_pkg::RAM_WIDTH,
    parameter int ADDR_SIZE     = dpram_pkg::ADDR_SIZE,
    parameter int BANK_SEL_BITS = dpram_pkg::BANK_SEL_BITS,
    parameter int NUM_BANKS     = 2 ** BANK_SEL_BITS,
    parameter int RSP_DEPTH     = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_req_valid,
    output logic                              wr_req_ready,
    input  logic [BANK_SEL_BITS+ADDR_SIZE-1:0] wr_req_addr,
    input  logic [RAM_WIDTH-1:0]              wr_req_data,
    input  logic                              rd_req_valid,
    output logic                              rd_req_ready,
    input  logic [BANK_SEL_BITS+ADDR_SIZE-1:0] rd_req_addr,
    output logic                              rd_rsp_valid,
    input  logic                              rd_rsp_ready,
    output logic [RAM_WIDTH-1:0]              rd_rsp_data,
    output logic [NUM_BANKS-1:0]              mem_wr_en,
    output logic [NUM_BANKS-1:0]              mem_rd_en,
    output logic                              write,
    output logic                              read,
    output logic [ADDR_SIZE-1:0]              wr_address,
    output logic [ADDR_SIZE-1:0]              rd_address,
    output logic [RAM_WIDTH-1:0]              data_in,
    input  logic [NUM_BANKS*RAM_WIDTH-1:0]    bank_data_out,
    input  logic [NUM_BANKS-1:0]              bank_data_valid
);

    import dpram_pkg::*;

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    logic [CNT_W-1:0]     credits;
    rd_stage_t            rd_s1;      // read issued to the banks this cycle
    rd_stage_t            rd_s2;      // read whose data the banks return this cycle
    logic                 proto_err;  // sticky: tracked read came back without data_valid
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 rsp_pop;
    logic                 rsp_push;
    logic                 rsp_full;
    logic                 rsp_empty;
    logic                 rd_drop;
    logic [RAM_WIDTH-1:0] sel_dat;
    logic                 sel_vld;

    assign wr_req_ready = 1'b1;
    assign rd_req_ready = (credits < CNT_W'(RSP_DEPTH));
    assign wr_acc       = wr_req_valid & wr_req_ready;
    assign rd_acc       = rd_req_valid & rd_req_ready;
    assign rd_rsp_valid = ~rsp_empty;
    assign rsp_pop      = rd_rsp_valid & rd_rsp_ready;

    // Only the bank recorded for the tracked read is looked at; any other
    // bank's data_valid (or one with no read tracked) is ignored.
    always_comb begin
        sel_dat = '0;
        sel_vld = 1'b0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (rd_s2.bank == BANK_SEL_BITS'(k)) begin
                sel_dat = bank_data_out[k*RAM_WIDTH +: RAM_WIDTH];
                sel_vld = bank_data_valid[k];
            end
        end
    end

    assign rsp_push = rd_s2.vld & sel_vld;
    assign rd_drop  = rd_s2.vld & ~sel_vld;

    // Bank-side request registers: enables pulse for exactly one cycle per accept.
    // Address/data hold their last value; they are qualified by the enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_en  <= '0;
            write      <= 1'b0;
            wr_address <= '0;
            data_in    <= '0;
            mem_rd_en  <= '0;
            read       <= 1'b0;
            rd_address <= '0;
            rd_s1      <= '0;
            rd_s2      <= '0;
        end else begin
            mem_wr_en <= wr_acc ? bank_onehot(bank_sel(wr_req_addr)) : '0;
            write     <= wr_acc;
            if (wr_acc) begin
                wr_address <= wr_req_addr[ADDR_SIZE-1:0];
                data_in    <= wr_req_data;
            end
            mem_rd_en  <= rd_acc ? bank_onehot(bank_sel(rd_req_addr)) : '0;
            read       <= rd_acc;
            if (rd_acc) begin
                rd_address <= rd_req_addr[ADDR_SIZE-1:0];
            end
            rd_s1.vld  <= rd_acc;
            rd_s1.bank <= bank_sel(rd_req_addr);
            rd_s2      <= rd_s1;
        end
    end

    // Credits cover every read between accept and response pop. A read the
    // bank failed to answer will never be popped, so its credit is returned
    // when it is dropped rather than leaking capacity forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits   <= '0;
            proto_err <= 1'b0;
        end else begin
            credits <= credits + CNT_W'(rd_acc) - CNT_W'(rsp_pop) - CNT_W'(rd_drop);
            if (rd_drop) begin
                proto_err <= 1'b1;
            end
        end
    end

    dpram_rsp_fifo #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rsp_push),
        .push_dat (sel_dat),
        .pop      (rsp_pop),
        .pop_dat  (rd_rsp_data),
        .full     (rsp_full),
        .empty    (rsp_empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(rsp_push && rsp_full));
    a_no_proto_err: assert property (@(posedge clk) disable iff (!rst_n) !proto_err);

endmodule
